// File: rtl/xm23_pic_pkg.sv
// Shared types and constants for the XM23 priority interrupt controller.
package xm23_pic_pkg;

  localparam int unsigned PIC_NUM_DEV = 4;
  localparam int unsigned PIC_PRI_W   = 3;

  localparam int unsigned PIC_KB    = 0;
  localparam int unsigned PIC_SCR   = 1;
  localparam int unsigned PIC_TMR   = 2;
  localparam int unsigned PIC_SPARE = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } pic_state_t;

endpackage

// File: rtl/xm23_pic_prio_sel.sv
// Combinational arbiter: highest priority among eligible devices, lowest index on ties.
module xm23_pic_prio_sel
  import xm23_pic_pkg::*;
#(
  parameter int unsigned NUM_DEV = PIC_NUM_DEV,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_DEV-1:0]                elig,
  input  logic [NUM_DEV-1:0][PIC_PRI_W-1:0] pri,
  output logic [IDX_W-1:0]                  win_idx_c,
  output logic                              win_vld_c
);

  logic [PIC_PRI_W-1:0] best_pri;

  // Strictly-greater compare while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_idx_c = '0;
    win_vld_c = 1'b0;
    best_pri  = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      if (elig[i] && (!win_vld_c || (pri[i] > best_pri))) begin
        win_idx_c = IDX_W'(i);
        win_vld_c = 1'b1;
        best_pri  = pri[i];
      end
    end
  end

endmodule

// File: rtl/xm23_pic.sv
// XM23 priority interrupt controller: edge capture, priority masking, vector handshake.
// Optional overflow flags (ovf_o) are built when XM23_PIC_OVF_EN is defined.
module xm23_pic
  import xm23_pic_pkg::*;
#(
  parameter int unsigned NUM_DEV   = PIC_NUM_DEV,
  parameter int unsigned VECT_BASE = 8
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [NUM_DEV-1:0]   dev_irq,
  input  logic [PIC_PRI_W-1:0] cur_pri,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_dev,
  input  logic [PIC_PRI_W-1:0] cfg_pri,
  input  logic                 cfg_ie,
  input  logic                 irq_ack,
  output logic                 irq_req,
  output logic [3:0]           irq_vect,
  output logic [PIC_PRI_W-1:0] irq_pri,
  output logic [NUM_DEV-1:0]   pend_o
`ifdef XM23_PIC_OVF_EN
  ,
  output logic [NUM_DEV-1:0]   ovf_o
`endif
);

  localparam int unsigned IDX_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned VECT_W = 4;

  pic_state_t                      state_q, state_d;
  logic [NUM_DEV-1:0]              irq_prev_q, irq_prev_d;
  logic [NUM_DEV-1:0]              pend_q, pend_d;
  logic [NUM_DEV-1:0]              ie_q, ie_d;
  logic [NUM_DEV-1:0][PIC_PRI_W-1:0] pri_q, pri_d;
  logic [IDX_W-1:0]                sel_q, sel_d;
  logic                            irq_req_q, irq_req_d;
  logic [VECT_W-1:0]               irq_vect_q, irq_vect_d;
  logic [PIC_PRI_W-1:0]            irq_pri_q, irq_pri_d;
`ifdef XM23_PIC_OVF_EN
  logic [NUM_DEV-1:0]              ovf_q, ovf_d;
`endif

  logic [NUM_DEV-1:0] set_c, elig_c, ack_clr_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               win_vld_c;

  // Accepted rising edges and per-device eligibility against the CPU priority.
  always_comb begin
    set_c  = dev_irq & ~irq_prev_q & ie_q;
    elig_c = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      elig_c[i] = pend_q[i] & ie_q[i] & (pri_q[i] > cur_pri);
    end
  end

  xm23_pic_prio_sel #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_prio_sel (
    .elig      (elig_c),
    .pri       (pri_q),
    .win_idx_c (win_idx_c),
    .win_vld_c (win_vld_c)
  );

  always_comb begin
    state_d    = state_q;
    irq_prev_d = dev_irq;
    ie_d       = ie_q;
    pri_d      = pri_q;
    sel_d      = sel_q;
    irq_req_d  = irq_req_q;
    irq_vect_d = irq_vect_q;
    irq_pri_d  = irq_pri_q;
    ack_clr_c  = '0;

    case (state_q)
      IDLE: begin
        if (win_vld_c) begin
          sel_d      = win_idx_c;
          irq_vect_d = VECT_W'(VECT_BASE) + VECT_W'(win_idx_c);
          irq_pri_d  = pri_q[win_idx_c];
          irq_req_d  = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          ack_clr_c[sel_q] = 1'b1;
          irq_req_d        = 1'b0;
          state_d          = HOLD;
        end else if (!ie_q[sel_q] || (cur_pri >= irq_pri_q)) begin
          irq_req_d = 1'b0;
          state_d   = HOLD;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new edge in the acknowledge cycle re-arms the request.
    pend_d = (pend_q & ~ack_clr_c) | set_c;
`ifdef XM23_PIC_OVF_EN
    ovf_d = (ovf_q | (set_c & pend_q & ~ack_clr_c)) & ~ack_clr_c;
`endif

    if (cfg_we) begin
      pri_d[cfg_dev] = cfg_pri;
      ie_d[cfg_dev]  = cfg_ie;
      if (!cfg_ie) begin
        pend_d[cfg_dev] = 1'b0;
      end
`ifdef XM23_PIC_OVF_EN
      ovf_d[cfg_dev] = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      ie_q       <= '0;
      pri_q      <= '0;
      sel_q      <= '0;
      irq_req_q  <= 1'b0;
      irq_vect_q <= '0;
      irq_pri_q  <= '0;
`ifdef XM23_PIC_OVF_EN
      ovf_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pend_q     <= pend_d;
      ie_q       <= ie_d;
      pri_q      <= pri_d;
      sel_q      <= sel_d;
      irq_req_q  <= irq_req_d;
      irq_vect_q <= irq_vect_d;
      irq_pri_q  <= irq_pri_d;
`ifdef XM23_PIC_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign irq_req  = irq_req_q;
  assign irq_vect = irq_vect_q;
  assign irq_pri  = irq_pri_q;
  assign pend_o   = pend_q;
`ifdef XM23_PIC_OVF_EN
  assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_xm23_pic.sv
// Directed self-checking bench for xm23_pic; overflow checks run when XM23_PIC_OVF_EN is defined.
module tb_xm23_pic;

  logic       Clock;
  logic       Reset_n;
  logic [3:0] dev_irq;
  logic [2:0] cur_pri;
  logic       cfg_we;
  logic [1:0] cfg_dev;
  logic [2:0] cfg_pri;
  logic       cfg_ie;
  logic       irq_ack;
  logic       irq_req;
  logic [3:0] irq_vect;
  logic [2:0] irq_pri;
  logic [3:0] pend_o;
`ifdef XM23_PIC_OVF_EN
  logic [3:0] ovf_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  xm23_pic #(
    .NUM_DEV   (4),
    .VECT_BASE (8)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .dev_irq  (dev_irq),
    .cur_pri  (cur_pri),
    .cfg_we   (cfg_we),
    .cfg_dev  (cfg_dev),
    .cfg_pri  (cfg_pri),
    .cfg_ie   (cfg_ie),
    .irq_ack  (irq_ack),
    .irq_req  (irq_req),
    .irq_vect (irq_vect),
    .irq_pri  (irq_pri),
    .pend_o   (pend_o)
`ifdef XM23_PIC_OVF_EN
    ,
    .ovf_o    (ovf_o)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic cfg(input logic [1:0] dev, input logic [2:0] pri, input logic ie);
    cfg_we  = 1'b1;
    cfg_dev = dev;
    cfg_pri = pri;
    cfg_ie  = ie;
    tick();
    cfg_we  = 1'b0;
  endtask

  // Check the presented vector, acknowledge it, and walk through the HOLD gap.
  task automatic ack_next(input string tag, input logic [3:0] vect, input logic [2:0] pri);
    chk({tag, "_req"}, 32'(irq_req), 32'd1);
    chk({tag, "_vect"}, 32'(irq_vect), 32'(vect));
    chk({tag, "_pri"}, 32'(irq_pri), 32'(pri));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk({tag, "_ack_drop"}, 32'(irq_req), 32'd0);
    tick();
    chk({tag, "_hold_gap"}, 32'(irq_req), 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    dev_irq = '0;
    cur_pri = '0;
    cfg_we  = 1'b0;
    cfg_dev = '0;
    cfg_pri = '0;
    cfg_ie  = 1'b0;
    irq_ack = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_vect", 32'(irq_vect), 32'd0);
    chk("rst_pri", 32'(irq_pri), 32'd0);
    chk("rst_pend", 32'(pend_o), 32'd0);
`ifdef XM23_PIC_OVF_EN
    chk("rst_ovf", 32'(ovf_o), 32'd0);
`endif
    Reset_n = 1'b1;
    tick();

    // Single request: dev2 pri 5 above cur_pri 2 -> vector 10.
    cur_pri = 3'd2;
    cfg(2'd2, 3'd5, 1'b1);
    dev_irq = 4'b0100;
    tick();
    dev_irq = 4'b0000;
    chk("single_pend", 32'(pend_o), 32'b0100);
    chk("single_req_lat", 32'(irq_req), 32'd0);
    tick();
    ack_next("single", 4'd10, 3'd5);
    chk("single_pend_clr", 32'(pend_o), 32'd0);

    // Arbitration: dev1/dev3 tie at 6 (lower index first), then dev0 at 4.
    cfg(2'd0, 3'd4, 1'b1);
    cfg(2'd1, 3'd6, 1'b1);
    cfg(2'd3, 3'd6, 1'b1);
    dev_irq = 4'b1011;
    tick();
    dev_irq = 4'b0000;
    chk("arb_pend", 32'(pend_o), 32'b1011);
    tick();
    ack_next("arb1", 4'd9, 3'd6);
    tick();
    ack_next("arb2", 4'd11, 3'd6);
    tick();
    ack_next("arb3", 4'd8, 3'd4);
    chk("arb_pend_clr", 32'(pend_o), 32'd0);

    // Masking: dev1 pri 3 equal to cur_pri 3 is not eligible.
    cur_pri = 3'd3;
    cfg(2'd1, 3'd3, 1'b1);
    dev_irq = 4'b0010;
    tick();
    dev_irq = 4'b0000;
    tick();
    tick();
    chk("mask_req", 32'(irq_req), 32'd0);
    chk("mask_pend", 32'(pend_o), 32'b0010);
    cur_pri = 3'd2;
    tick();
    chk("unmask_req", 32'(irq_req), 32'd1);
    chk("unmask_vect", 32'(irq_vect), 32'd9);

    // Withdrawal: cur_pri rises above the presented priority without ack.
    cur_pri = 3'd5;
    tick();
    chk("wd_req", 32'(irq_req), 32'd0);
    chk("wd_pend", 32'(pend_o), 32'b0010);
    chk("wd_vect_kept", 32'(irq_vect), 32'd9);
    tick();
    tick();
    chk("wd_still_masked", 32'(irq_req), 32'd0);
    cur_pri = 3'd2;
    tick();
    ack_next("wd_resume", 4'd9, 3'd3);

    // Ack collision: new dev0 edge in the ack cycle keeps pend set.
    dev_irq = 4'b0001;
    tick();
    dev_irq = 4'b0000;
    tick();
    chk("coll_req", 32'(irq_req), 32'd1);
    chk("coll_vect", 32'(irq_vect), 32'd8);
    irq_ack = 1'b1;
    dev_irq = 4'b0001;
    tick();
    irq_ack = 1'b0;
    dev_irq = 4'b0000;
    chk("coll_ack_drop", 32'(irq_req), 32'd0);
    chk("coll_pend_kept", 32'(pend_o), 32'b0001);
`ifdef XM23_PIC_OVF_EN
    chk("coll_no_ovf", 32'(ovf_o), 32'd0);
`endif
    tick();
    chk("coll_gap", 32'(irq_req), 32'd0);
    tick();
    ack_next("coll_again", 4'd8, 3'd4);

    // Disabling a device drops its pending request; disabled edges are ignored.
    cur_pri = 3'd7;
    dev_irq = 4'b1000;
    tick();
    dev_irq = 4'b0000;
    chk("dis_pend_set", 32'(pend_o), 32'b1000);
    cfg(2'd3, 3'd6, 1'b0);
    chk("dis_pend_clr", 32'(pend_o), 32'd0);
    dev_irq = 4'b1000;
    tick();
    dev_irq = 4'b0000;
    chk("dis_edge_drop", 32'(pend_o), 32'd0);

    // Priority 0 is never eligible even with cur_pri 0; reprogramming takes effect next cycle.
    cfg(2'd2, 3'd0, 1'b1);
    cur_pri = 3'd0;
    dev_irq = 4'b0100;
    tick();
    dev_irq = 4'b0000;
    tick();
    tick();
    chk("pri0_req", 32'(irq_req), 32'd0);
    chk("pri0_pend", 32'(pend_o), 32'b0100);
    cfg(2'd2, 3'd5, 1'b1);
    chk("cfg_lat_req", 32'(irq_req), 32'd0);
    tick();
    chk("cfg_req", 32'(irq_req), 32'd1);
    chk("cfg_vect", 32'(irq_vect), 32'd10);

    // Second dev2 edge while presenting merges (and flags overflow when built).
    dev_irq = 4'b0100;
    tick();
    dev_irq = 4'b0000;
    chk("rep_req", 32'(irq_req), 32'd1);
    chk("rep_pend", 32'(pend_o), 32'b0100);
`ifdef XM23_PIC_OVF_EN
    chk("ovf_set", 32'(ovf_o), 32'b0100);
`endif
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("rep_ack_pend", 32'(pend_o), 32'd0);
`ifdef XM23_PIC_OVF_EN
    chk("ovf_ack_clr", 32'(ovf_o), 32'd0);
`endif
    tick();
    tick();

    // Asynchronous reset in PRESENT clears outputs without a clock edge.
    dev_irq = 4'b0100;
    tick();
    dev_irq = 4'b0000;
    tick();
    chk("pre_rst_req", 32'(irq_req), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(irq_req), 32'd0);
    chk("arst_vect", 32'(irq_vect), 32'd0);
    chk("arst_pri", 32'(irq_pri), 32'd0);
    chk("arst_pend", 32'(pend_o), 32'd0);
`ifdef XM23_PIC_OVF_EN
    chk("arst_ovf", 32'(ovf_o), 32'd0);
`endif
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post_rst_req", 32'(irq_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
